// File: rtl/inst_dispatch_sched.sv
// -----------------------------------------------------------------------------
// inst_dispatch_sched
//   In-order instruction sequencer for the streaming TPU subsystem. Fetches
//   instruction words over the RD_* interface, decodes them and dispatches
//   each payload to Mover1, Mover2 or the TPU through drive/free handshakes.
//   Completion is reported through FINISH and a STATUS_SEND/STATUS_INFO pulse.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   CAN_READ_INST       program start enable (level)
//   FINISH              high while in the DONE state
//   STATUS_SEND         one-cycle pulse, STATUS_INFO valid
//   STATUS_INFO[31:0]   {stall_cnt[14:0], illegal, inst_cnt[15:0]}
//   RD_START, RD_ADDR   one-cycle fetch request and its address
//   RD_DATA, RD_DONE    fetched word and its one-cycle completion strobe
//   o_drive2*           one-cycle dispatch pulse per unit
//   o_data2*            payload, held from a drive until the next drive
//   i_freeF*            one-cycle completion pulse from each unit
//
// Optional build macro
//   SCHED_PERF_CNT_EN   adds a 15-bit saturating stall counter reported in
//                       STATUS_INFO[31:17]; when undefined those bits are 0.
// -----------------------------------------------------------------------------
module inst_dispatch_sched #(
  parameter int INST_W    = 64,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CAN_READ_INST,
  output logic              FINISH,
  output logic              STATUS_SEND,
  output logic [31:0]       STATUS_INFO,
  output logic              RD_START,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [INST_W-1:0] RD_DATA,
  input  logic              RD_DONE,
  output logic              o_drive2Mover1,
  output logic              o_drive2Mover2,
  output logic              o_drive2TPU,
  output logic [INST_W-5:0] o_data2Mover1,
  output logic [INST_W-5:0] o_data2Mover2,
  output logic [INST_W-5:0] o_data2TPU,
  input  logic              i_freeF_Mover1,
  input  logic              i_freeF_Mover2,
  input  logic              i_freeFTPU
);

  localparam int PW = INST_W - 4;
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MOVER1 = 4'h1;
  localparam logic [3:0] OP_MOVER2 = 4'h2;
  localparam logic [3:0] OP_TPU    = 4'h3;
  localparam logic [3:0] OP_SYNC   = 4'h4;
  localparam logic [3:0] OP_END    = 4'hF;

  // DRAIN is the part of DONE that waits for outstanding units; DONE proper
  // is entered once everything is idle and the status word has been sent.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_REQ  = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_DISPATCH   = 3'd4,
    S_SYNC_WAIT  = 3'd5,
    S_DRAIN      = 3'd6,
    S_DONE       = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [2:0]          busy_q, busy_d;
  logic [15:0]         inst_cnt_q, inst_cnt_d;
  logic                illegal_q, illegal_d;
  logic                rd_start_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                finish_q;
  logic                status_send_q, status_send_d;
  logic [31:0]         status_q, status_d;
  logic [PW-1:0]       data1_q, data2_q, data3_q;

  logic [3:0]          opcode_s;
  logic [PW-1:0]       payload_s;
  logic [2:0]          sel_s;
  logic [2:0]          fire_s;
  logic [2:0]          free_s;
  logic [14:0]         stall_val_s;

  assign opcode_s  = inst_q[INST_W-1 -: 4];
  assign payload_s = inst_q[PW-1:0];
  assign free_s    = {i_freeFTPU, i_freeF_Mover2, i_freeF_Mover1};

  // Target unit of the latched instruction as a one-hot {TPU, Mover2, Mover1}.
  always_comb begin
    case (opcode_s)
      OP_MOVER1: sel_s = 3'b001;
      OP_MOVER2: sel_s = 3'b010;
      OP_TPU:    sel_s = 3'b100;
      default:   sel_s = 3'b000;
    endcase
  end

  // Next-state logic for the sequencer FSM, counters and busy flags.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_cnt_d    = inst_cnt_q;
    illegal_d     = illegal_q;
    status_d      = status_q;
    status_send_d = 1'b0;
    fire_s        = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (CAN_READ_INST) begin
          state_d    = S_FETCH_REQ;
          pc_d       = BASE;
          inst_cnt_d = 16'd0;
          illegal_d  = 1'b0;
          status_d   = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_REQ: state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (RD_DONE) begin
          inst_d  = RD_DATA;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH_WAIT;
        end
      end
      S_DECODE: begin
        case (opcode_s)
          OP_MOVER1, OP_MOVER2, OP_TPU: state_d = S_DISPATCH;
          OP_SYNC: state_d = S_SYNC_WAIT;
          OP_END:  state_d = S_DRAIN;
          OP_NOP: begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH_REQ;
          end
          default: begin
            illegal_d = 1'b1;
            pc_d      = pc_q + PC_ONE;
            state_d   = S_FETCH_REQ;
          end
        endcase
      end
      S_DISPATCH: begin
        // Busy is sampled from the register, so a free arriving during a
        // stall lets the drive go out on the following cycle.
        if ((busy_q & sel_s) == 3'b000) begin
          fire_s  = sel_s;
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH_REQ;
          if (inst_cnt_q != 16'hFFFF) begin
            inst_cnt_d = inst_cnt_q + 16'd1;
          end else begin
            inst_cnt_d = inst_cnt_q;
          end
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_SYNC_WAIT: begin
        if (busy_q == 3'b000) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH_REQ;
        end else begin
          state_d = S_SYNC_WAIT;
        end
      end
      S_DRAIN: begin
        if (busy_q == 3'b000) begin
          state_d       = S_DONE;
          status_send_d = 1'b1;
          status_d      = {stall_val_s, illegal_q, inst_cnt_q};
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!CAN_READ_INST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (busy_q & ~free_s) | fire_s;
  end

  // Sequencer state, counters, busy flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= BASE;
      inst_q        <= {INST_W{1'b0}};
      busy_q        <= 3'b000;
      inst_cnt_q    <= 16'd0;
      illegal_q     <= 1'b0;
      rd_start_q    <= 1'b0;
      rd_addr_q     <= {ADDR_W{1'b0}};
      finish_q      <= 1'b0;
      status_send_q <= 1'b0;
      status_q      <= 32'd0;
      data1_q       <= {PW{1'b0}};
      data2_q       <= {PW{1'b0}};
      data3_q       <= {PW{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      busy_q        <= busy_d;
      inst_cnt_q    <= inst_cnt_d;
      illegal_q     <= illegal_d;
      rd_start_q    <= (state_d == S_FETCH_REQ);
      rd_addr_q     <= (state_d == S_FETCH_REQ) ? pc_d : rd_addr_q;
      finish_q      <= (state_d == S_DONE);
      status_send_q <= status_send_d;
      status_q      <= status_d;
      data1_q       <= fire_s[0] ? payload_s : data1_q;
      data2_q       <= fire_s[1] ? payload_s : data2_q;
      data3_q       <= fire_s[2] ? payload_s : data3_q;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [14:0] stall_q, stall_d;
  logic        stall_cycle_s;
  logic        start_s;

  // Stall cycles: blocked dispatch, or waiting on any busy unit in SYNC/DONE.
  always_comb begin
    start_s       = (state_q == S_IDLE) && CAN_READ_INST;
    stall_cycle_s = ((state_q == S_DISPATCH) && ((busy_q & sel_s) != 3'b000)) ||
                    (((state_q == S_SYNC_WAIT) || (state_q == S_DRAIN)) && (busy_q != 3'b000));
    if (start_s) begin
      stall_d = 15'd0;
    end else if (stall_cycle_s && (stall_q != 15'h7FFF)) begin
      stall_d = stall_q + 15'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Saturating stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 15'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_val_s = stall_q;
`else
  assign stall_val_s = 15'd0;
`endif

  // Drives are decoded from registered state only; the data bus shows the
  // new payload in the drive cycle and then holds it.
  assign o_drive2Mover1 = fire_s[0];
  assign o_drive2Mover2 = fire_s[1];
  assign o_drive2TPU    = fire_s[2];
  assign o_data2Mover1  = fire_s[0] ? payload_s : data1_q;
  assign o_data2Mover2  = fire_s[1] ? payload_s : data2_q;
  assign o_data2TPU     = fire_s[2] ? payload_s : data3_q;

  assign RD_START    = rd_start_q;
  assign RD_ADDR     = rd_addr_q;
  assign FINISH      = finish_q;
  assign STATUS_SEND = status_send_q;
  assign STATUS_INFO = status_q;

endmodule

// File: tb/tb_inst_dispatch_sched.sv
// -----------------------------------------------------------------------------
// tb_inst_dispatch_sched
//   Bench for inst_dispatch_sched. A memory model answers fetches after a fixed
//   latency, unit models return a free pulse a programmable time after each
//   drive, and a monitor logs drives, frees, fetches and status words. Each
//   test loads a program, pushes the expected fetches/drives into scoreboard
//   queues and pops them against the logged DUT activity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_dispatch_sched;
  localparam int INST_W = 64;
  localparam int ADDR_W = 16;
  localparam int PW     = INST_W - 4;

  logic              clk;
  logic              rst;
  logic              can_read;
  logic              rd_done;
  logic [INST_W-1:0] rd_data;
  logic [2:0]        free_v;
  logic              finish, status_send, rd_start;
  logic [31:0]       status_info;
  logic [ADDR_W-1:0] rd_addr;
  logic              drv1, drv2, drv3;
  logic [PW-1:0]     d1, d2, d3;

  inst_dispatch_sched #(.INST_W(INST_W), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .CAN_READ_INST(can_read),
    .FINISH(finish), .STATUS_SEND(status_send), .STATUS_INFO(status_info),
    .RD_START(rd_start), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_DONE(rd_done),
    .o_drive2Mover1(drv1), .o_drive2Mover2(drv2), .o_drive2TPU(drv3),
    .o_data2Mover1(d1), .o_data2Mover2(d2), .o_data2TPU(d3),
    .i_freeF_Mover1(free_v[0]), .i_freeF_Mover2(free_v[1]), .i_freeFTPU(free_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Logs written only by the monitor / responder processes.
  int            drv_u[$];
  logic [PW-1:0] drv_d[$];
  int            drv_c[$];
  int            fr_u[$];
  int            fr_c[$];
  int            fa[$];
  int            fc[$];
  logic [31:0]   st_log[$];

  // Stimulus configuration written only by the main process.
  logic [INST_W-1:0] prog [0:15];
  int                mem_lat;
  int                free_lat [3];

  // Scoreboard of expected activity.
  int            exp_a[$];
  int            exp_u[$];
  logic [PW-1:0] exp_d[$];

  int n_vec;
  int n_err;

  // Monitor: log drives, fetch requests and status pulses mid-cycle.
  initial forever begin
    @(negedge clk);
    if (drv1) begin drv_u.push_back(0); drv_d.push_back(d1); drv_c.push_back(cyc); end
    if (drv2) begin drv_u.push_back(1); drv_d.push_back(d2); drv_c.push_back(cyc); end
    if (drv3) begin drv_u.push_back(2); drv_d.push_back(d3); drv_c.push_back(cyc); end
    if (rd_start) begin fa.push_back(int'(rd_addr)); fc.push_back(cyc); end
    if (status_send) st_log.push_back(status_info);
  end

  // Instruction memory: RD_DONE with data mem_lat cycles after RD_START.
  int                mem_cnt;
  logic [ADDR_W-1:0] mem_addr;
  initial begin
    rd_done = 1'b0; rd_data = '0; mem_cnt = 0; mem_addr = '0;
    forever begin
      @(negedge clk);
      rd_done = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rd_done = 1'b1;
          rd_data = prog[mem_addr[3:0]];
        end
      end
      if (rd_start) begin
        mem_addr = rd_addr;
        mem_cnt  = mem_lat;
      end
    end
  end

  // Execution units: free pulse free_lat cycles after each drive.
  int u_cnt [3];
  initial begin
    free_v = 3'b000;
    for (int i = 0; i < 3; i++) u_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        free_v[i] = 1'b0;
        if (u_cnt[i] > 0) begin
          u_cnt[i]--;
          if (u_cnt[i] == 0) begin
            free_v[i] = 1'b1;
            fr_u.push_back(i);
            fr_c.push_back(cyc);
          end
        end
      end
      if (drv1) u_cnt[0] = free_lat[0];
      if (drv2) u_cnt[1] = free_lat[1];
      if (drv3) u_cnt[2] = free_lat[2];
    end
  end

  function automatic logic [INST_W-1:0] mk(input logic [3:0] op, input logic [PW-1:0] p);
    return {op, p};
  endfunction

  // Fill the scoreboard from prog[0..n-1]: every word is fetched, unit ops drive.
  task automatic load(input int n);
    logic [3:0] op;
    exp_a.delete(); exp_u.delete(); exp_d.delete();
    for (int i = 0; i < n; i++) begin
      op = prog[i][INST_W-1 -: 4];
      exp_a.push_back(i);
      if (op >= 4'h1 && op <= 4'h3) begin
        exp_u.push_back(int'(op) - 1);
        exp_d.push_back(prog[i][PW-1:0]);
      end
    end
  endtask

  task automatic run(output bit ok);
    ok = 1'b0;
    @(negedge clk); can_read = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (finish) ok = 1'b1;
    end
  endtask

  task automatic stop();
    @(negedge clk); can_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; can_read = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({finish, status_send, rd_start} !== 3'b000) begin n_err++; $display("FAIL rst_ctrl: %b required 000", {finish, status_send, rd_start}); end
    n_vec++; if (status_info !== 32'd0) begin n_err++; $display("FAIL rst_status: %h required 0", status_info); end
    n_vec++; if (rd_addr !== 16'd0) begin n_err++; $display("FAIL rst_addr: %h required 0", rd_addr); end
    n_vec++; if ({drv1, drv2, drv3} !== 3'b000) begin n_err++; $display("FAIL rst_drive: %b required 000", {drv1, drv2, drv3}); end
    n_vec++; if ({d1, d2, d3} !== {(3*PW){1'b0}}) begin n_err++; $display("FAIL rst_data: %h %h %h required 0", d1, d2, d3); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if ({rd_start, finish} !== 2'b00) begin n_err++; $display("FAIL rst_idle: %b required 00", {rd_start, finish}); end
  endtask

  task automatic test_fetch_dispatch();
    int d0, f0, s0, eu, ea, nd, nf; logic [PW-1:0] ed; bit ok;
    prog[0] = mk(4'h1, 60'h1); prog[1] = mk(4'h3, 60'h2); prog[2] = mk(4'hF, 60'h0);
    free_lat[0] = 5; free_lat[1] = 5; free_lat[2] = 5;
    d0 = drv_u.size(); f0 = fa.size(); s0 = st_log.size();
    load(3);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fd_finish: FINISH=%b required 1", finish); end
    nf = fa.size() - f0;
    n_vec++; if (nf != exp_a.size()) begin n_err++; $display("FAIL fd_fetch_count: %0d required %0d", nf, exp_a.size()); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      if (f0 < fa.size()) begin
        n_vec++; if (fa[f0] != ea) begin n_err++; $display("FAIL fd_fetch_addr: %0d required %0d", fa[f0], ea); end
        f0++;
      end
    end
    nd = drv_u.size() - d0;
    n_vec++; if (nd != exp_u.size()) begin n_err++; $display("FAIL fd_drive_count: %0d required %0d", nd, exp_u.size()); end
    while (exp_u.size() > 0) begin
      eu = exp_u.pop_front(); ed = exp_d.pop_front();
      if (d0 < drv_u.size()) begin
        n_vec++; if (drv_u[d0] != eu || drv_d[d0] !== ed) begin n_err++; $display("FAIL fd_drive: unit %0d data %h required unit %0d data %h", drv_u[d0], drv_d[d0], eu, ed); end
        d0++;
      end
    end
    n_vec++; if (st_log.size() != s0 + 1) begin n_err++; $display("FAIL fd_status_pulses: %0d required 1", st_log.size() - s0); end
    n_vec++; if (status_info[16:0] !== {1'b0, 16'd2}) begin n_err++; $display("FAIL fd_status: %h required 00002", status_info[16:0]); end
    stop();
  endtask

  task automatic test_busy_stall();
    int d0, dstart, fr0, fm, eu, nd; logic [PW-1:0] ed; bit ok;
    prog[0] = mk(4'h2, 60'hA1); prog[1] = mk(4'h2, 60'hB2); prog[2] = mk(4'hF, 60'h0);
    free_lat[0] = 5; free_lat[1] = 20; free_lat[2] = 5;
    d0 = drv_u.size(); dstart = d0; fr0 = fr_u.size();
    load(3);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bs_finish: FINISH=%b required 1", finish); end
    nd = drv_u.size() - d0;
    n_vec++; if (nd != exp_u.size()) begin n_err++; $display("FAIL bs_drive_count: %0d required %0d", nd, exp_u.size()); end
    while (exp_u.size() > 0) begin
      eu = exp_u.pop_front(); ed = exp_d.pop_front();
      if (d0 < drv_u.size()) begin
        n_vec++; if (drv_u[d0] != eu || drv_d[d0] !== ed) begin n_err++; $display("FAIL bs_drive: unit %0d data %h required unit %0d data %h", drv_u[d0], drv_d[d0], eu, ed); end
        d0++;
      end
    end
    fm = -1;
    for (int i = fr0; i < fr_u.size(); i++) if (fm < 0 && fr_u[i] == 1) fm = fr_c[i];
    n_vec++;
    if (drv_c.size() < dstart + 2 || drv_c[dstart+1] != fm + 1) begin
      n_err++; $display("FAIL bs_redrive_cycle: %0d required %0d", (drv_c.size() < dstart + 2) ? -1 : drv_c[dstart+1], fm + 1);
    end
    n_vec++; if (status_info[16:0] !== {1'b0, 16'd2}) begin n_err++; $display("FAIL bs_status: %h required 00002", status_info[16:0]); end
`ifdef SCHED_PERF_CNT_EN
    n_vec++; if (status_info[31:17] == 15'd0) begin n_err++; $display("FAIL bs_stall_cnt: %0d required >0", status_info[31:17]); end
`else
    n_vec++; if (status_info[31:17] !== 15'd0) begin n_err++; $display("FAIL bs_stall_cnt: %0d required 0", status_info[31:17]); end
`endif
    stop();
  endtask

  task automatic test_sync();
    int d0, f0, fr0, ft, eu, ea, nd; logic [PW-1:0] ed; bit ok;
    prog[0] = mk(4'h1, 60'h11); prog[1] = mk(4'h3, 60'h22); prog[2] = mk(4'h4, 60'h0);
    prog[3] = mk(4'h2, 60'h33); prog[4] = mk(4'hF, 60'h0);
    free_lat[0] = 5; free_lat[1] = 5; free_lat[2] = 30;
    d0 = drv_u.size(); f0 = fa.size(); fr0 = fr_u.size();
    load(5);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL sy_finish: FINISH=%b required 1", finish); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      n_vec++;
      if (f0 >= fa.size() || fa[f0] != ea) begin n_err++; $display("FAIL sy_fetch_addr: %0d required %0d", (f0 < fa.size()) ? fa[f0] : -1, ea); end
      f0++;
    end
    ft = -1;
    for (int i = fr0; i < fr_u.size(); i++) if (ft < 0 && fr_u[i] == 2) ft = fr_c[i];
    n_vec++;
    if (fc.size() < f0 - 1 || ft < 0 || fc[f0-2] <= ft) begin
      n_err++; $display("FAIL sy_fetch3_cycle: %0d required > %0d", (fc.size() >= f0 - 1) ? fc[f0-2] : -1, ft);
    end
    nd = drv_u.size() - d0;
    n_vec++; if (nd != exp_u.size()) begin n_err++; $display("FAIL sy_drive_count: %0d required %0d", nd, exp_u.size()); end
    while (exp_u.size() > 0) begin
      eu = exp_u.pop_front(); ed = exp_d.pop_front();
      if (d0 < drv_u.size()) begin
        n_vec++; if (drv_u[d0] != eu || drv_d[d0] !== ed) begin n_err++; $display("FAIL sy_drive: unit %0d data %h required unit %0d data %h", drv_u[d0], drv_d[d0], eu, ed); end
        d0++;
      end
    end
    n_vec++; if (status_info[16:0] !== {1'b0, 16'd3}) begin n_err++; $display("FAIL sy_status: %h required 00003", status_info[16:0]); end
    stop();
  endtask

  task automatic test_illegal_nop();
    int d0, eu, nd; logic [PW-1:0] ed; bit ok;
    prog[0] = mk(4'h7, 60'h123); prog[1] = mk(4'h0, 60'h456); prog[2] = mk(4'h1, 60'h9); prog[3] = mk(4'hF, 60'h0);
    free_lat[0] = 5; free_lat[1] = 5; free_lat[2] = 5;
    d0 = drv_u.size();
    load(4);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL il_finish: FINISH=%b required 1", finish); end
    nd = drv_u.size() - d0;
    n_vec++; if (nd != exp_u.size()) begin n_err++; $display("FAIL il_drive_count: %0d required %0d", nd, exp_u.size()); end
    while (exp_u.size() > 0) begin
      eu = exp_u.pop_front(); ed = exp_d.pop_front();
      if (d0 < drv_u.size()) begin
        n_vec++; if (drv_u[d0] != eu || drv_d[d0] !== ed) begin n_err++; $display("FAIL il_drive: unit %0d data %h required unit %0d data %h", drv_u[d0], drv_d[d0], eu, ed); end
        d0++;
      end
    end
    n_vec++; if (status_info[16:0] !== {1'b1, 16'd1}) begin n_err++; $display("FAIL il_status: %h required 10001", status_info[16:0]); end
    stop();
  endtask

  task automatic test_reset_midrun();
    int d0, f0, f1, eu, nd; logic [PW-1:0] ed; bit ok; bit seen;
    prog[0] = mk(4'h0, 60'h0); prog[1] = mk(4'h1, 60'h55); prog[2] = mk(4'hF, 60'h0);
    d0 = drv_u.size(); f0 = fa.size();
    @(negedge clk); can_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (fa.size() >= f0 + 2) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rm_second_fetch: %0d fetches required 2", fa.size() - f0); end
    @(negedge clk); rst = 1'b1; can_read = 1'b0;
    @(negedge clk);
    n_vec++; if ({finish, status_send, rd_start, drv1, drv2, drv3} !== 6'd0) begin n_err++; $display("FAIL rm_ctrl: %b required 000000", {finish, status_send, rd_start, drv1, drv2, drv3}); end
    n_vec++; if ({rd_addr, status_info, d1, d2, d3} !== '0) begin n_err++; $display("FAIL rm_buses: addr %h status %h required 0", rd_addr, status_info); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_vec++; if (drv_u.size() != d0) begin n_err++; $display("FAIL rm_no_drive: %0d drives required 0", drv_u.size() - d0); end
    n_vec++; if (fa.size() != f0 + 2) begin n_err++; $display("FAIL rm_no_fetch: %0d fetches required 2", fa.size() - f0); end
    f1 = fa.size();
    load(3);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rm_finish: FINISH=%b required 1", finish); end
    n_vec++; if (fa.size() <= f1 || fa[f1] != 0) begin n_err++; $display("FAIL rm_restart_addr: %0d required 0", (fa.size() > f1) ? fa[f1] : -1); end
    nd = drv_u.size() - d0;
    n_vec++; if (nd != exp_u.size()) begin n_err++; $display("FAIL rm_drive_count: %0d required %0d", nd, exp_u.size()); end
    while (exp_u.size() > 0) begin
      eu = exp_u.pop_front(); ed = exp_d.pop_front();
      if (d0 < drv_u.size()) begin
        n_vec++; if (drv_u[d0] != eu || drv_d[d0] !== ed) begin n_err++; $display("FAIL rm_drive: unit %0d data %h required unit %0d data %h", drv_u[d0], drv_d[d0], eu, ed); end
        d0++;
      end
    end
    stop();
  endtask

  task automatic test_restart();
    int f0, ea; bit ok;
    prog[0] = mk(4'h1, 60'hA); prog[1] = mk(4'h3, 60'hB); prog[2] = mk(4'hF, 60'h0);
    free_lat[0] = 5; free_lat[1] = 5; free_lat[2] = 5;
    load(3);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rs_finish1: FINISH=%b required 1", finish); end
    repeat (5) @(negedge clk);
    n_vec++; if (finish !== 1'b1) begin n_err++; $display("FAIL rs_finish_hold: %b required 1", finish); end
    can_read = 1'b0;
    @(negedge clk);
    n_vec++; if (finish !== 1'b0) begin n_err++; $display("FAIL rs_finish_drop: %b required 0", finish); end
    n_vec++; if (status_info[15:0] !== 16'd2) begin n_err++; $display("FAIL rs_status_hold: %0d required 2", status_info[15:0]); end
    repeat (2) @(negedge clk);
    f0 = fa.size();
    load(3);
    run(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rs_finish2: FINISH=%b required 1", finish); end
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      n_vec++;
      if (f0 >= fa.size() || fa[f0] != ea) begin n_err++; $display("FAIL rs_fetch_addr: %0d required %0d", (f0 < fa.size()) ? fa[f0] : -1, ea); end
      f0++;
    end
    n_vec++; if (status_info[16:0] !== {1'b0, 16'd2}) begin n_err++; $display("FAIL rs_inst_cnt: %h required 00002", status_info[16:0]); end
    stop();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; can_read = 1'b0; mem_lat = 3;
    free_lat[0] = 5; free_lat[1] = 5; free_lat[2] = 5;
    test_reset();
    test_fetch_dispatch();
    test_busy_stall();
    test_sync();
    test_illegal_nop();
    test_reset_midrun();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_dispatch_sched.md
Name: inst_dispatch_sched

Overview:
- Synchronous instruction sequencer for the streaming TPU subsystem.
- Fetches instruction words from instruction memory over the RD_START/RD_ADDR/RD_DATA/RD_DONE interface, then decodes them.
- Dispatches each payload in program order to Mover1, Mover2 or the TPU over drive/free handshakes.
- Tracks per-unit busy state and reports completion through FINISH and a STATUS_SEND/STATUS_INFO pulse.

Parameters:
- INST_W, 64: instruction word width; opcode in [INST_W-1:INST_W-4], payload in [INST_W-5:0].
- ADDR_W, 16: instruction address width.
- BASE_ADDR, 0: first fetch address after each start.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- CAN_READ_INST  in  1  level; program start enable.
- FINISH  out  1  level; high in DONE state.
- STATUS_SEND  out  1  one-cycle pulse; STATUS_INFO valid.
- STATUS_INFO  out  32  completion status word.
- RD_START  out  1  one-cycle fetch request.
- RD_ADDR  out  ADDR_W  fetch address; valid with RD_START.
- RD_DATA  in  INST_W  fetched word; valid with RD_DONE.
- RD_DONE  in  1  one-cycle fetch completion.
- o_drive2Mover1 / o_drive2Mover2 / o_drive2TPU  out  1  one-cycle dispatch pulse per unit.
- o_data2Mover1 / o_data2Mover2 / o_data2TPU  out  INST_W-4  payload; held stable from drive until next drive to that unit.
- i_freeF_Mover1 / i_freeF_Mover2 / i_freeFTPU  in  1  one-cycle completion pulse from the unit.

Behaviour:
- Reset (async, rst=1): state IDLE, pc=BASE_ADDR, all busy flags 0, counters 0. All outputs 0, including data buses and RD_ADDR.
- Opcodes:
  - 0x0 NOP
  - 0x1 MOVER1
  - 0x2 MOVER2
  - 0x3 TPU
  - 0x4 SYNC: wait until all three busy flags are 0
  - 0xF END
  - any other value is illegal: executed as NOP and sets the sticky illegal flag.
- IDLE: CAN_READ_INST=1 -> FETCH_REQ. pc, counters and the illegal flag are cleared on this transition.
- FETCH_REQ: RD_START=1 and RD_ADDR=pc for exactly one cycle -> FETCH_WAIT.
- FETCH_WAIT: on RD_DONE, latch RD_DATA -> DECODE. Memory latency is unbounded. RD_DONE outside FETCH_WAIT is ignored.
- DECODE, one cycle:
  - MOVER1/MOVER2/TPU -> DISPATCH.
  - SYNC -> SYNC_WAIT.
  - END -> DONE.
  - NOP/illegal: pc+1 -> FETCH_REQ.
- DISPATCH:
  - If the target busy flag is 0: pulse that unit's drive, drive its data bus with the payload, set busy, increment inst_cnt, pc+1 -> FETCH_REQ.
  - Otherwise stay in DISPATCH.
  - Minimum dispatch-to-next-fetch latency: drive at cycle N, RD_START at N+1.
- SYNC_WAIT: when all busy flags are 0, pc+1 -> FETCH_REQ.
- DONE:
  - Wait in DONE until all busy flags are 0.
  - Then emit STATUS_SEND for one cycle and raise FINISH, holding FINISH while CAN_READ_INST=1.
  - CAN_READ_INST=0 -> IDLE, with FINISH cleared on the same edge.
- Busy flags:
  - Set by own drive, cleared by own free.
  - Free and a stall on the same unit in the same cycle: busy clears that cycle, drive issues the next cycle.
  - Free while not busy: ignored.
  - Drive and free of the same unit in the same cycle is impossible by construction.
- CAN_READ_INST deasserted mid-program: no effect until DONE; the program runs to END.
- pc wraps modulo 2^ADDR_W.
- inst_cnt (16 bits) counts dispatched MOVER1/MOVER2/TPU instructions and saturates at 0xFFFF.
- STATUS_INFO layout:
  - [15:0] inst_cnt
  - [16] illegal flag
  - [31:17] stall count (see Optional Feature), else 0.
- STATUS_INFO holds its value until the next start.
- rst mid-operation: immediate return to IDLE. In-flight unit completions and RD_DONE arriving after reset are ignored.

Optional Feature:
- SCHED_PERF_CNT_EN defined:
  - 15-bit saturating stall counter, incremented each cycle spent in DISPATCH with the target busy, or in SYNC_WAIT/DONE with any unit busy.
  - Reported in STATUS_INFO[31:17]; cleared on start.
- Undefined: no counter logic; STATUS_INFO[31:17]=0.

Test Plan:
- Fetch and dispatch:
  - Stimulus: program {MOVER1 p=0x1, TPU p=0x2, END}; RD_DONE 3 cycles after each RD_START; each unit frees 5 cycles after its drive.
  - Response: RD_ADDR 0,1,2; one drive each with matching payload; FINISH=1; STATUS_INFO[15:0]=2, [16]=0.
- Busy stall:
  - Stimulus: {MOVER2 a, MOVER2 b, END}; free delayed 20 cycles.
  - Response: second o_drive2Mover2 occurs the cycle after i_freeF_Mover2. With SCHED_PERF_CNT_EN, stall count >0.
- SYNC:
  - Stimulus: {MOVER1, TPU, SYNC, MOVER2, END}; TPU frees 30 cycles after its drive.
  - Response: RD_START for addr 3 not issued before the cycle after the TPU free.
- Illegal/NOP:
  - Stimulus: {0x7.., NOP, MOVER1, END}.
  - Response: only the Mover1 drive; STATUS_INFO[16]=1, [15:0]=1.
- Reset mid-run:
  - Stimulus: rst pulse while in FETCH_WAIT, then a late RD_DONE.
  - Response: all outputs 0, no drive; after restart, RD_ADDR=BASE_ADDR.
- Restart:
  - Stimulus: hold CAN_READ_INST=1 through DONE, drop it, raise it again.
  - Response: FINISH falls on the drop edge, the program refetches from 0, and inst_cnt is reset.
